// File: rtl/reg_bank_4x32_if.sv
// ---------------------------------------------------------------------------
// reg_bank_4x32_if
// Purpose : Groups the write handshake, the clear control and the register
//           outputs of reg_bank_4x32 into one bundle.
// Signals :
//   wr_valid  requester -> bank   write request present
//   wr_ready  bank -> requester   bank accepts a write this cycle
//   wr_addr   requester -> bank   target register index (0..3)
//   wr_data   requester -> bank   write data, WIDTH bits
//   clr_req   requester -> bank   request sequenced clear of all registers
//   busy      bank -> requester   clear sequence in progress
//   q0..q3    bank -> downstream  registered contents, WIDTH bits each
//   written   bank -> downstream  bit i set = register i loaded since
//                                 last reset/clear
// Modports: master (requester / testbench side), slave (register bank).
// ---------------------------------------------------------------------------
interface reg_bank_4x32_if #(
    parameter int WIDTH = 32
);
    logic             wr_valid;
    logic             wr_ready;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             clr_req;
    logic             busy;
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;
    logic [WIDTH-1:0] q3;
    logic [3:0]       written;

    modport master (
        output wr_valid, wr_addr, wr_data, clr_req,
        input  wr_ready, busy, q0, q1, q2, q3, written
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, clr_req,
        output wr_ready, busy, q0, q1, q2, q3, written
    );
endinterface

// File: rtl/reg_bank_4x32.sv
// ---------------------------------------------------------------------------
// reg_bank_4x32
// Purpose : Four-entry register bank feeding a downstream 4:1 read mux.
//           Single-word writes via valid/ready; a clear request zeroes the
//           registers one per cycle (q0 first, q3 last) while busy is high.
//           Per-register written flags mark entries loaded since the last
//           reset or clear.
// Ports   :
//   clk    input   single clock, rising edge
//   reset  input   synchronous, active-high; aborts any clear in progress
//   bus    reg_bank_4x32_if.slave  handshake, clear control, q0..q3, written
// Parameters:
//   WIDTH      register / data width
//   CLR_VALUE  value loaded by reset or clear
// ---------------------------------------------------------------------------
module reg_bank_4x32 #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_bank_4x32_if.slave       bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_clr_idx;
    logic [WIDTH-1:0] r_q [4];
    logic [3:0]       r_written;

    logic             w_wr_ready;
    logic             w_wr_fire;

    // A pending clear request blocks writes in the same cycle, which is what
    // gives clear priority over a simultaneous write.
    assign w_wr_ready = (r_state == ST_IDLE) && !bus.clr_req;
    assign w_wr_fire  = bus.wr_valid && w_wr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_clr_idx <= 2'd0;
            r_written <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= CLR_VALUE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        // Entry edge only arms the sequence; nothing is cleared yet.
                        r_state   <= ST_CLEAR;
                        r_clr_idx <= 2'd0;
                    end else if (w_wr_fire) begin
                        r_q[bus.wr_addr]       <= bus.wr_data;
                        r_written[bus.wr_addr] <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // clr_req is deliberately not looked at here, so a repeat
                    // request cannot restart or extend the sequence.
                    r_q[r_clr_idx]       <= CLR_VALUE;
                    r_written[r_clr_idx] <= 1'b0;
                    r_clr_idx            <= r_clr_idx + 2'd1;
                    if (r_clr_idx == 2'd3) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wr_ready = w_wr_ready;
    assign bus.busy     = (r_state == ST_CLEAR);
    assign bus.q0       = r_q[0];
    assign bus.q1       = r_q[1];
    assign bus.q2       = r_q[2];
    assign bus.q3       = r_q[3];
    assign bus.written  = r_written;

endmodule

// File: tb/tb_reg_bank_4x32.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_4x32
// Bench for reg_bank_4x32: directed scenarios plus a randomized run, all
// compared against a behavioural model of the bank held in this module.
// ---------------------------------------------------------------------------
module tb_reg_bank_4x32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    reg_bank_4x32_if #(.WIDTH(32)) bus ();

    reg_bank_4x32 #(.WIDTH(32), .CLR_VALUE(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] dq [4];
    assign dq[0] = bus.q0;
    assign dq[1] = bus.q1;
    assign dq[2] = bus.q2;
    assign dq[3] = bus.q3;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: register contents, written flags, and how many
    // registers a running clear still has to zero (0 = no clear running).
    logic [31:0] m_q [4];
    logic [3:0]  m_w;
    int          clr_left;

    function automatic logic m_busy();
        return clr_left > 0;
    endfunction

    function automatic logic m_ready();
        return (clr_left == 0) && !bus.clr_req;
    endfunction

    // Advance one rising edge, applying the bank's rules to the inputs that
    // were presented during the cycle, then settle past the edge.
    task automatic tick();
        int k;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 4; i++) m_q[i] = 32'h0;
            m_w      = 4'b0000;
            clr_left = 0;
        end else if (clr_left > 0) begin
            k = 4 - clr_left;
            m_q[k]   = 32'h0;
            m_w[k]   = 1'b0;
            clr_left = clr_left - 1;
        end else if (bus.clr_req) begin
            clr_left = 4;
        end else if (bus.wr_valid) begin
            m_q[bus.wr_addr] = bus.wr_data;
            m_w[bus.wr_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        bus.wr_valid = 1'($urandom);
        bus.wr_addr  = 2'($urandom);
        bus.wr_data  = $urandom;
        bus.clr_req  = 1'($urandom);
        reset        = 1'b1;
        tick();
        bus.wr_valid = 1'($urandom);
        bus.clr_req  = 1'($urandom);
        tick();
        reset        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.clr_req  = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dq[i] !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_q%0d: got %h expected %h", i, dq[i], 32'h0);
            end
        end
        n_checks++;
        if (bus.written !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_written: got %b expected 0000", bus.written);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
        n_checks++;
        if (bus.wr_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready: got %b expected 1", bus.wr_ready);
        end
    endtask

    task automatic test_writes();
        logic [31:0] vals [4];
        vals[0] = 32'h11111111;
        vals[1] = 32'h22222222;
        vals[2] = 32'h33333333;
        vals[3] = 32'h44444444;
        for (int a = 0; a < 4; a++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 2'(a);
            bus.wr_data  = vals[a];
            #1;
            n_checks++;
            if (bus.wr_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL wr_ready_%0d: got %b expected 1", a, bus.wr_ready);
            end
            tick();
            n_checks++;
            if (dq[a] !== vals[a]) begin
                n_errors++;
                $display("FAIL wr_q%0d: got %h expected %h", a, dq[a], vals[a]);
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (dq[i] !== m_q[i]) begin
                    n_errors++;
                    $display("FAIL wr_model_q%0d: got %h expected %h", i, dq[i], m_q[i]);
                end
            end
        end
        bus.wr_valid = 1'b0;
        n_checks++;
        if (bus.written !== 4'b1111) begin
            n_errors++;
            $display("FAIL wr_written: got %b expected 1111", bus.written);
        end
    endtask

    task automatic test_clear();
        logic [3:0] exp_w [4];
        exp_w[0] = 4'b1110;
        exp_w[1] = 4'b1100;
        exp_w[2] = 4'b1000;
        exp_w[3] = 4'b0000;
        bus.clr_req = 1'b1;
        #1;
        n_checks++;
        if (bus.wr_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_ready_req: got %b expected 0", bus.wr_ready);
        end
        tick();                                 // E0
        bus.clr_req = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b1 || dq[0] !== 32'h11111111) begin
            n_errors++;
            $display("FAIL clr_e0: busy %b q0 %h expected busy 1 q0 11111111", bus.busy, dq[0]);
        end
        for (int e = 0; e < 4; e++) begin
            n_checks++;
            if (bus.wr_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL clr_ready_e%0d: got %b expected 0", e, bus.wr_ready);
            end
            tick();                             // E1..E4
            n_checks++;
            if (dq[e] !== 32'h0) begin
                n_errors++;
                $display("FAIL clr_q%0d: got %h expected 0", e, dq[e]);
            end
            n_checks++;
            if (bus.written !== exp_w[e]) begin
                n_errors++;
                $display("FAIL clr_written_e%0d: got %b expected %b", e + 1, bus.written, exp_w[e]);
            end
            n_checks++;
            if (bus.busy !== m_busy()) begin
                n_errors++;
                $display("FAIL clr_busy_e%0d: got %b expected %b", e + 1, bus.busy, m_busy());
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (dq[i] !== m_q[i]) begin
                    n_errors++;
                    $display("FAIL clr_model_q%0d: got %h expected %h", i, dq[i], m_q[i]);
                end
            end
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.wr_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL clr_end: busy %b ready %b expected busy 0 ready 1", bus.busy, bus.wr_ready);
        end
    endtask

    task automatic test_collision();
        int waited;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 2'd2;
        bus.wr_data  = 32'hDEADBEEF;
        bus.clr_req  = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        n_checks++;
        if (dq[2] !== m_q[2] || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL coll_e0: q2 %h busy %b expected q2 %h busy 1", dq[2], bus.busy, m_q[2]);
        end
        waited = 0;
        while (bus.wr_ready !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        n_checks++;
        if (waited != 4) begin
            n_errors++;
            $display("FAIL coll_wait: got %0d cycles expected 4", waited);
        end
        tick();
        bus.wr_valid = 1'b0;
        n_checks++;
        if (dq[2] !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL coll_q2: got %h expected deadbeef", dq[2]);
        end
        n_checks++;
        if (bus.written !== m_w) begin
            n_errors++;
            $display("FAIL coll_written: got %b expected %b", bus.written, m_w);
        end
    endtask

    task automatic test_midclear();
        for (int a = 0; a < 4; a++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 2'(a);
            bus.wr_data  = (a == 3) ? 32'h44444444 : $urandom;
            tick();
        end
        bus.wr_valid = 1'b0;
        // Re-pulse of clr_req across E2 must be ignored.
        bus.clr_req = 1'b1;
        tick();                                 // E0
        bus.clr_req = 1'b0;
        tick();                                 // E1
        bus.clr_req = 1'b1;
        tick();                                 // E2
        bus.clr_req = 1'b0;
        tick();                                 // E3
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_busy_e3: got %b expected 1", bus.busy);
        end
        tick();                                 // E4
        n_checks++;
        if (bus.busy !== 1'b0 || bus.written !== 4'b0000) begin
            n_errors++;
            $display("FAIL mid_end_e4: busy %b written %b expected 0 0000", bus.busy, bus.written);
        end
        // Reset landing on E2 aborts the clear.
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 2'd3;
        bus.wr_data  = 32'h44444444;
        tick();
        bus.wr_valid = 1'b0;
        bus.clr_req  = 1'b1;
        tick();                                 // E0
        bus.clr_req  = 1'b0;
        tick();                                 // E1
        reset = 1'b1;
        tick();                                 // E2
        reset = 1'b0;
        #1;
        n_checks++;
        if (dq[3] !== 32'h0) begin
            n_errors++;
            $display("FAIL rst_mid_q3: got %h expected 0", dq[3]);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.wr_ready !== 1'b1 || bus.written !== 4'b0000) begin
            n_errors++;
            $display("FAIL rst_mid_ctl: busy %b ready %b written %b expected 0 1 0000",
                     bus.busy, bus.wr_ready, bus.written);
        end
    endtask

    task automatic test_overwrite();
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 2'd0;
        bus.wr_data  = 32'h0F0F0F0F;
        tick();
        bus.wr_addr  = 2'd1;
        bus.wr_data  = 32'hAAAA0000;
        tick();
        bus.wr_data  = 32'h0000BBBB;
        tick();
        bus.wr_valid = 1'b0;
        n_checks++;
        if (dq[1] !== 32'h0000BBBB) begin
            n_errors++;
            $display("FAIL ovw_q1: got %h expected 0000bbbb", dq[1]);
        end
        n_checks++;
        if (bus.written !== 4'b0011) begin
            n_errors++;
            $display("FAIL ovw_written: got %b expected 0011", bus.written);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dq[i] !== m_q[i]) begin
                n_errors++;
                $display("FAIL ovw_model_q%0d: got %h expected %h", i, dq[i], m_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.wr_valid = 1'($urandom);
            bus.wr_addr  = 2'($urandom);
            bus.wr_data  = $urandom;
            bus.clr_req  = ($urandom_range(0, 11) == 0);
            reset        = ($urandom_range(0, 59) == 0);
            #1;
            n_checks++;
            if (bus.wr_ready !== m_ready()) begin
                n_errors++;
                $display("FAIL rnd_ready_c%0d: got %b expected %b", c, bus.wr_ready, m_ready());
            end
            tick();
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (dq[i] !== m_q[i]) begin
                    n_errors++;
                    $display("FAIL rnd_q%0d_c%0d: got %h expected %h", i, c, dq[i], m_q[i]);
                end
            end
            n_checks++;
            if (bus.written !== m_w || bus.busy !== m_busy()) begin
                n_errors++;
                $display("FAIL rnd_ctl_c%0d: written %b busy %b expected %b %b",
                         c, bus.written, bus.busy, m_w, m_busy());
            end
        end
        reset        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.clr_req  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_q[i] = 32'h0;
        m_w          = 4'b0000;
        clr_left     = 0;
        reset        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = 2'd0;
        bus.wr_data  = 32'h0;
        bus.clr_req  = 1'b0;
        #2;
        test_reset();
        test_writes();
        test_clear();
        test_collision();
        test_midclear();
        test_overwrite();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_4x32.md
# reg_bank_4x32

Four-entry, 32-bit register bank that holds the values driving the q0..q3 inputs of the 2-bit-select read multiplexer directly downstream. It accepts single-word writes through a valid/ready handshake. It also supports a sequenced clear operation that zeroes the bank one register per cycle. Per-register "written" flags let downstream logic distinguish loaded entries from reset/cleared ones.

## Interface
Parameters:
- WIDTH, 32, data width of each register and of wr_data / q0..q3
- CLR_VALUE, 0, value loaded into a register by reset or clear

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- wr_valid  input  1  write request present
- wr_ready  output  1  bank can accept a write this cycle
- wr_addr  input  2  target register (00→q0, 01→q1, 10→q2, 11→q3)
- wr_data  input  WIDTH  write data
- clr_req  input  1  request sequenced clear of all four registers
- busy  output  1  clear sequence in progress
- q0, q1, q2, q3  output  WIDTH each  registered contents, fed to downstream mux
- written  output  4  bit i = register i written since last reset/clear

## Operation
- States: IDLE and CLEAR; 2-bit clear index clr_idx.
- wr_ready is combinational: 1 when state==IDLE and clr_req==0, else 0.
- Write is accepted on a rising edge where wr_valid && wr_ready. At that edge, register[wr_addr] ← wr_data and written[wr_addr] ← 1. Other registers are unchanged.
- Writes while wr_ready==0 are not accepted. The requester holds wr_valid, wr_addr and wr_data until acceptance. The bank keeps no internal write buffering.
- IDLE + clr_req==1 at an edge: go to CLEAR with clr_idx ← 0. No register is modified at that edge.
- Clear has priority over a simultaneous write. The write is not accepted because wr_ready is 0.
- CLEAR, each edge: register[clr_idx] ← CLR_VALUE, written[clr_idx] ← 0, clr_idx ← clr_idx+1.
- After the edge that clears register 3, state ← IDLE.
- clr_req asserted during CLEAR is ignored and does not restart or extend the sequence.
- clr_req still high on return to IDLE starts a new clear at the next edge.
- busy = (state==CLEAR).
- Reset has priority over everything and can occur at any time, including mid-clear. It aborts the sequence and sets:
  - q0..q3 = CLR_VALUE
  - written = 4'b0000
  - state = IDLE, clr_idx = 0
  - busy = 0
  - wr_ready = !clr_req
- wr_addr is always a valid index; no out-of-range case exists.
- Writing the same address on consecutive accepted cycles: the last write wins and written stays 1.

## Timing
- Write latency: data accepted at edge N is visible on the q output from edge N (registered output, stable during cycle N+1).
- Back-to-back writes are accepted every cycle in IDLE; throughput is 1 write/cycle.
- Clear latency: clr_req sampled at edge E0. q0..q3 are zeroed at edges E1..E4 respectively.
- busy is high from E0 to E4, i.e. exactly 4 cycles.
- wr_ready goes low combinationally in the cycle clr_req rises and stays low through CLEAR. It returns high after E4 if clr_req is low.
- Outputs change only on clock edges, except wr_ready, which is combinational from state and clr_req.

## Test plan
- Reset: assert reset 2 cycles with random inputs → q0..q3 = 0, written = 0000, busy = 0, wr_ready = 1 after release.
- Writes: write 0x11111111→addr0, 0x22222222→addr1, 0x33333333→addr2, 0x44444444→addr3 on 4 consecutive cycles → each q updates one edge after its write; written = 1111.
- Clear sequence: after the above, pulse clr_req 1 cycle → busy high 4 cycles; q0, q1, q2, q3 read 0 after E1, E2, E3, E4 respectively; written steps 1110→1100→1000→0000; wr_ready = 0 throughout.
- Collision: wr_valid=1, addr=2, data=0xDEADBEEF in the same cycle as clr_req in IDLE → write not accepted. Holding wr_valid, the write is accepted the cycle after busy falls, and q2 = 0xDEADBEEF one edge later.
- Mid-clear events: clr_req re-pulsed at E2 → ignored, busy still falls after E4. In a separate run, reset at E2 with q3 = 0x44444444 → q3 = 0 immediately, busy = 0, state IDLE.
- Overwrite: writes 0xAAAA0000 then 0x0000BBBB to addr1 on consecutive cycles → q1 = 0x0000BBBB, written[1] = 1, other registers unchanged.
